// File: rtl/hazard_ctrl.sv
// Stall and forwarding controller for the five-stage MIPS pipeline.
// Tracks in-flight writers in an E/M/W scoreboard and compares them with D-stage descriptors.
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [2:0] TuseRs,
  input  logic [2:0] TuseRt,
  input  logic [4:0] A3D,
  input  logic       WeD,
  input  logic [2:0] TnewD,
  output logic       Stall,
  output logic [1:0] FwdRsD,
  output logic [1:0] FwdRtD,
  output logic [1:0] FwdRsE,
  output logic [1:0] FwdRtE,
  output logic       FwdRtM
);

  logic [4:0] RsE, RtE, A3E;
  logic       WeE;
  logic [2:0] TnewE;
  logic [4:0] RtM, A3M;
  logic       WeM;
  logic [2:0] TnewM;
  logic [4:0] A3W;
  logic       WeW;

  logic live_e, live_m, live_w;
  logic rsd_e, rsd_m, rsd_w, rtd_e, rtd_m, rtd_w;
  logic rse_m, rse_w, rte_m, rte_w, rtm_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RsE   <= '0;
      RtE   <= '0;
      A3E   <= '0;
      WeE   <= 1'b0;
      TnewE <= '0;
      RtM   <= '0;
      A3M   <= '0;
      WeM   <= 1'b0;
      TnewM <= '0;
      A3W   <= '0;
      WeW   <= 1'b0;
    end else begin
      if (Stall) begin
        RsE   <= '0;
        RtE   <= '0;
        A3E   <= '0;
        WeE   <= 1'b0;
        TnewE <= '0;
      end else begin
        RsE   <= RsD;
        RtE   <= RtD;
        A3E   <= A3D;
        WeE   <= WeD;
        TnewE <= TnewD;
      end
      RtM   <= RtE;
      A3M   <= A3E;
      WeM   <= WeE;
      TnewM <= (TnewE == 3'd0) ? 3'd0 : TnewE - 3'd1;
      A3W   <= A3M;
      WeW   <= WeM;
    end
  end

  // Register 0 is never a live writer, so it can neither stall nor forward.
  always_comb begin
    live_e = WeE && (A3E != 5'd0);
    live_m = WeM && (A3M != 5'd0);
    live_w = WeW && (A3W != 5'd0);
    rsd_e  = live_e && (RsD == A3E);
    rsd_m  = live_m && (RsD == A3M);
    rsd_w  = live_w && (RsD == A3W);
    rtd_e  = live_e && (RtD == A3E);
    rtd_m  = live_m && (RtD == A3M);
    rtd_w  = live_w && (RtD == A3W);
    rse_m  = live_m && (RsE == A3M);
    rse_w  = live_w && (RsE == A3W);
    rte_m  = live_m && (RtE == A3M);
    rte_w  = live_w && (RtE == A3W);
    rtm_w  = live_w && (RtM == A3W);
  end

  always_comb begin
    Stall = (rsd_e && (TuseRs < TnewE)) || (rsd_m && (TuseRs < TnewM)) ||
            (rtd_e && (TuseRt < TnewE)) || (rtd_m && (TuseRt < TnewM));
  end

  // A newer match whose value is not ready yet yields 0 rather than falling back to an older stage.
  always_comb begin
    FwdRsD = rsd_e ? ((TnewE == 3'd0) ? 2'd3 : 2'd0) :
             rsd_m ? ((TnewM == 3'd0) ? 2'd2 : 2'd0) :
             rsd_w ? 2'd1 : 2'd0;
    FwdRtD = rtd_e ? ((TnewE == 3'd0) ? 2'd3 : 2'd0) :
             rtd_m ? ((TnewM == 3'd0) ? 2'd2 : 2'd0) :
             rtd_w ? 2'd1 : 2'd0;
    FwdRsE = rse_m ? ((TnewM == 3'd0) ? 2'd2 : 2'd0) :
             rse_w ? 2'd1 : 2'd0;
    FwdRtE = rte_m ? ((TnewM == 3'd0) ? 2'd2 : 2'd0) :
             rte_w ? 2'd1 : 2'd0;
    FwdRtM = rtm_w;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: instruction pairs with hand-derived stall lengths and forward selects.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] RsD = '0, RtD = '0, A3D = '0;
  logic [2:0] TuseRs = 3'd4, TuseRt = 3'd4, TnewD = '0;
  logic       WeD = 1'b0;
  logic       Stall, FwdRtM;
  logic [1:0] FwdRsD, FwdRtD, FwdRsE, FwdRtE;

  int checks = 0;
  int failures = 0;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .TuseRs(TuseRs), .TuseRt(TuseRt),
    .A3D(A3D), .WeD(WeD), .TnewD(TnewD), .Stall(Stall), .FwdRsD(FwdRsD), .FwdRtD(FwdRtD),
    .FwdRsE(FwdRsE), .FwdRtE(FwdRtE), .FwdRtM(FwdRtM)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [2:0] urs,
                       input logic [2:0] urt, input logic [4:0] a3, input logic we,
                       input logic [2:0] tn);
    RsD = rs; RtD = rt; TuseRs = urs; TuseRt = urt; A3D = a3; WeD = we; TnewD = tn;
    #1;
  endtask

  task automatic nop();
    set_d(5'd0, 5'd0, 3'd4, 3'd4, 5'd0, 1'b0, 3'd0);
  endtask

  task automatic do_reset();
    nop();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic count_stall(output int n);
    n = 0;
    while (Stall === 1'b1 && n < 6) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++;
    if ({Stall, FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM} !== 9'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 0", {Stall, FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM});
    end
    step();
    reset = 1'b0;
    set_d(5'd8, 5'd8, 3'd0, 3'd0, 5'd8, 1'b1, 3'd2);
    checks++;
    if (Stall !== 1'b0 || FwdRsD !== 2'd0) begin
      failures++;
      $display("FAIL reset_first_cycle: stall=%b fwdrsd=%0d expected 0/0", Stall, FwdRsD);
    end
  endtask

  task automatic test_load_use();
    int n;
    do_reset();
    set_d(5'd2, 5'd8, 3'd1, 3'd4, 5'd8, 1'b1, 3'd2);   // lw $8
    step();
    set_d(5'd8, 5'd9, 3'd1, 3'd1, 5'd10, 1'b1, 3'd1);  // addu rs=$8
    count_stall(n);
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL load_use_stall: got %0d cycles expected 1", n);
    end
    step();
    nop();
    checks++;
    if (FwdRsE !== 2'd1 || FwdRtE !== 2'd0) begin
      failures++;
      $display("FAIL load_use_fwd_e: rs=%0d rt=%0d expected 1/0", FwdRsE, FwdRtE);
    end
  endtask

  task automatic test_load_branch();
    int n;
    do_reset();
    set_d(5'd2, 5'd8, 3'd1, 3'd4, 5'd8, 1'b1, 3'd2);
    step();
    set_d(5'd8, 5'd9, 3'd0, 3'd0, 5'd0, 1'b0, 3'd0);   // beq $8,$9
    count_stall(n);
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL load_branch_stall: got %0d cycles expected 2", n);
    end
    checks++;
    if (FwdRsD !== 2'd1 || FwdRtD !== 2'd0) begin
      failures++;
      $display("FAIL load_branch_fwd_d: rs=%0d rt=%0d expected 1/0", FwdRsD, FwdRtD);
    end
  endtask

  task automatic test_alu_branch_same_reg();
    int n;
    do_reset();
    set_d(5'd3, 5'd4, 3'd1, 3'd1, 5'd5, 1'b1, 3'd1);   // addu $5
    step();
    set_d(5'd5, 5'd5, 3'd0, 3'd0, 5'd0, 1'b0, 3'd0);   // beq $5,$5
    count_stall(n);
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL alu_branch_stall: got %0d cycles expected 1", n);
    end
    checks++;
    if (FwdRsD !== 2'd2 || FwdRtD !== 2'd2) begin
      failures++;
      $display("FAIL alu_branch_fwd_d: rs=%0d rt=%0d expected 2/2", FwdRsD, FwdRtD);
    end
  endtask

  task automatic test_jal_jr();
    do_reset();
    set_d(5'd0, 5'd0, 3'd4, 3'd4, 5'd31, 1'b1, 3'd0);  // jal
    step();
    set_d(5'd31, 5'd0, 3'd0, 3'd4, 5'd0, 1'b0, 3'd0);  // jr $31
    checks++;
    if (Stall !== 1'b0 || FwdRsD !== 2'd3) begin
      failures++;
      $display("FAIL jal_jr: stall=%b fwdrsd=%0d expected 0/3", Stall, FwdRsD);
    end
  endtask

  task automatic test_load_store();
    do_reset();
    set_d(5'd2, 5'd7, 3'd1, 3'd4, 5'd7, 1'b1, 3'd2);   // lw $7
    step();
    set_d(5'd3, 5'd7, 3'd1, 3'd2, 5'd0, 1'b0, 3'd0);   // sw rt=$7
    checks++;
    if (Stall !== 1'b0) begin
      failures++;
      $display("FAIL store_no_stall: stall=%b expected 0", Stall);
    end
    step();
    nop();
    checks++;
    if (FwdRtE !== 2'd0) begin
      failures++;
      $display("FAIL store_fwd_e: got %0d expected 0", FwdRtE);
    end
    step();
    checks++;
    if (FwdRtM !== 1'b1) begin
      failures++;
      $display("FAIL store_fwd_m: got %b expected 1", FwdRtM);
    end
  endtask

  task automatic test_reg_zero();
    do_reset();
    set_d(5'd2, 5'd0, 3'd1, 3'd4, 5'd0, 1'b1, 3'd2);   // lw $0
    step();
    set_d(5'd0, 5'd0, 3'd0, 3'd0, 5'd10, 1'b1, 3'd1);
    checks++;
    if ({Stall, FwdRsD, FwdRtD} !== 5'd0) begin
      failures++;
      $display("FAIL zero_d: got %b expected 0", {Stall, FwdRsD, FwdRtD});
    end
    step();
    nop();
    step();
    checks++;
    if ({FwdRsE, FwdRtE, FwdRtM} !== 5'd0) begin
      failures++;
      $display("FAIL zero_em: got %b expected 0", {FwdRsE, FwdRtE, FwdRtM});
    end
  endtask

  // Two writers of $6: older ready in M, newer not ready in E.
  task automatic test_back_to_back();
    do_reset();
    set_d(5'd0, 5'd0, 3'd4, 3'd4, 5'd6, 1'b1, 3'd0);
    step();
    set_d(5'd1, 5'd1, 3'd1, 3'd1, 5'd6, 1'b1, 3'd1);
    step();
    set_d(5'd6, 5'd0, 3'd1, 3'd4, 5'd11, 1'b1, 3'd1);
    checks++;
    if (Stall !== 1'b0 || FwdRsD !== 2'd0) begin
      failures++;
      $display("FAIL b2b_block_d: stall=%b fwdrsd=%0d expected 0/0", Stall, FwdRsD);
    end
    step();
    nop();
    checks++;
    if (FwdRsE !== 2'd2) begin
      failures++;
      $display("FAIL b2b_fwd_e: got %0d expected 2", FwdRsE);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_d(5'd2, 5'd8, 3'd1, 3'd4, 5'd8, 1'b1, 3'd2);
    step();
    set_d(5'd8, 5'd8, 3'd0, 3'd0, 5'd0, 1'b0, 3'd0);
    checks++;
    if (Stall !== 1'b1) begin
      failures++;
      $display("FAIL mid_stall_pre: stall=%b expected 1", Stall);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (Stall !== 1'b0) begin
      failures++;
      $display("FAIL mid_stall_reset: stall=%b expected 0", Stall);
    end
    checks++;
    if ({dut.A3E, dut.WeE, dut.TnewE, dut.A3M, dut.WeM, dut.TnewM, dut.A3W, dut.WeW} !== '0) begin
      failures++;
      $display("FAIL mid_stall_scoreboard: A3E=%0d A3M=%0d A3W=%0d expected 0",
               dut.A3E, dut.A3M, dut.A3W);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (Stall !== 1'b0 || FwdRsD !== 2'd0) begin
      failures++;
      $display("FAIL mid_stall_release: stall=%b fwdrsd=%0d expected 0/0", Stall, FwdRsD);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_load_branch();
    test_alu_branch_same_reg();
    test_jal_jr();
    test_load_store();
    test_reg_zero();
    test_back_to_back();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
